// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALT   = 2'd1,
        RESUME = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam int         CNT_W_DEFAULT = 32;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use compare: the ID instruction needs a register that the load in EX
// has not produced yet.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_use_rs_i,
    input  logic       id_use_rt_i,
    input  logic [4:0] ex_wr_reg_i,
    input  logic       ex_mem_read_i,
    output logic       lu_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_use_rs_i && (id_rs_i == ex_wr_reg_i);
    assign rt_hit = id_use_rt_i && (id_rt_i == ex_wr_reg_i);
    // r0 is hardwired, so a load targeting it never creates a dependency
    assign lu_o   = ex_mem_read_i && (ex_wr_reg_i != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/halt strobes for the PC and the
// four pipeline registers, plus cycle/stall/flush statistics.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             in_CLK,
    input  logic             in_CLR,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_wr_reg,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             wb_halt,
    input  logic             in_go,
    output logic             out_pc_en,
    output logic             out_ifid_en,
    output logic             out_idex_en,
    output logic             out_exmem_en,
    output logic             out_memwb_en,
    output logic             out_ifid_clr,
    output logic             out_idex_clr,
    output logic             out_halted,
    output logic [CNT_W-1:0] out_cycles,
    output logic [CNT_W-1:0] out_stalls,
    output logic [CNT_W-1:0] out_flushes
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] stalls_q, stalls_d;
    logic [CNT_W-1:0] flushes_q, flushes_d;
    logic             lu;
    logic             stall_apply;
    logic             flush_apply;

    hazard_detect u_hazard_detect (
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_use_rs_i   (id_use_rs),
        .id_use_rt_i   (id_use_rt),
        .ex_wr_reg_i   (ex_wr_reg),
        .ex_mem_read_i (ex_mem_read),
        .lu_o          (lu)
    );

    always_ff @(posedge in_CLK or posedge in_CLR) begin
        if (in_CLR) begin
            state_q   <= RUN;
            cycles_q  <= '0;
            stalls_q  <= '0;
            flushes_q <= '0;
        end else begin
            state_q   <= state_d;
            cycles_q  <= cycles_d;
            stalls_q  <= stalls_d;
            flushes_q <= flushes_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        out_pc_en    = 1'b0;
        out_ifid_en  = 1'b0;
        out_idex_en  = 1'b0;
        out_exmem_en = 1'b0;
        out_memwb_en = 1'b0;
        out_ifid_clr = 1'b0;
        out_idex_clr = 1'b0;
        stall_apply  = 1'b0;
        flush_apply  = 1'b0;

        // Strobes are forced low while the asynchronous clear is held
        if (!in_CLR) begin
            case (state_q)
                HALT: begin
                    if (in_go) state_d = RESUME;
                end
                RUN, RESUME: begin
                    if (state_q == RESUME) state_d = RUN;
                    // The halt is still leaving WB during RESUME, so it only counts from RUN
                    if (state_q == RUN && wb_halt) begin
                        state_d = HALT;
                    end else if (ex_branch_taken) begin
                        flush_apply  = 1'b1;
                        out_pc_en    = 1'b1;
                        out_ifid_en  = 1'b1;
                        out_idex_en  = 1'b1;
                        out_exmem_en = 1'b1;
                        out_memwb_en = 1'b1;
                        out_ifid_clr = 1'b1;
                        out_idex_clr = 1'b1;
                    end else if (lu) begin
                        stall_apply  = 1'b1;
                        out_idex_en  = 1'b1;
                        out_exmem_en = 1'b1;
                        out_memwb_en = 1'b1;
                        out_idex_clr = 1'b1;
                    end else begin
                        out_pc_en    = 1'b1;
                        out_ifid_en  = 1'b1;
                        out_idex_en  = 1'b1;
                        out_exmem_en = 1'b1;
                        out_memwb_en = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        cycles_d  = cycles_q;
        stalls_d  = stalls_q;
        flushes_d = flushes_q;
        if (state_q != HALT) cycles_d = cycles_q + CNT_W'(1);
        if (stall_apply)     stalls_d = stalls_q + CNT_W'(1);
        if (flush_apply)     flushes_d = flushes_q + CNT_W'(1);
    end

    assign out_halted  = (state_q == HALT);
    assign out_cycles  = cycles_q;
    assign out_stalls  = stalls_q;
    assign out_flushes = flushes_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: expected strobe vectors are
// queued as stimulus is applied and compared at the following falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int K_NORM  = 0;
    localparam int K_STALL = 1;
    localparam int K_FLUSH = 2;
    localparam int K_FRZ   = 3;

    // {pc, ifid, idex, exmem, memwb, ifid_clr, idex_clr, halted}
    localparam logic [7:0] S_NORM   = 8'b11111_00_0;
    localparam logic [7:0] S_FLUSH  = 8'b11111_11_0;
    localparam logic [7:0] S_STALL  = 8'b00111_01_0;
    localparam logic [7:0] S_FRZ    = 8'b00000_00_0;
    localparam logic [7:0] S_HALTED = 8'b00000_00_1;

    logic        in_CLK = 1'b0;
    logic        in_CLR;
    logic [4:0]  id_rs, id_rt, ex_wr_reg;
    logic        id_use_rs, id_use_rt, ex_mem_read, ex_branch_taken, wb_halt, in_go;
    logic        out_pc_en, out_ifid_en, out_idex_en, out_exmem_en, out_memwb_en;
    logic        out_ifid_clr, out_idex_clr, out_halted;
    logic [31:0] out_cycles, out_stalls, out_flushes;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sb[$];
    logic [7:0]  exp_s;
    logic [31:0] mcyc, mstall, mflush;
    int          mstate;

    pipeline_hazard_ctrl #(.CNT_W(32)) dut (
        .in_CLK          (in_CLK),
        .in_CLR          (in_CLR),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .ex_wr_reg       (ex_wr_reg),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .wb_halt         (wb_halt),
        .in_go           (in_go),
        .out_pc_en       (out_pc_en),
        .out_ifid_en     (out_ifid_en),
        .out_idex_en     (out_idex_en),
        .out_exmem_en    (out_exmem_en),
        .out_memwb_en    (out_memwb_en),
        .out_ifid_clr    (out_ifid_clr),
        .out_idex_clr    (out_idex_clr),
        .out_halted      (out_halted),
        .out_cycles      (out_cycles),
        .out_stalls      (out_stalls),
        .out_flushes     (out_flushes)
    );

    always #5 in_CLK = ~in_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    function automatic logic [7:0] strb_now();
        return {out_pc_en, out_ifid_en, out_idex_en, out_exmem_en, out_memwb_en,
                out_ifid_clr, out_idex_clr, out_halted};
    endfunction

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_wr_reg = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        wb_halt = 1'b0; in_go = 1'b0;
    endtask

    task automatic model_reset();
        mcyc = 0; mstall = 0; mflush = 0; mstate = 0;
    endtask

    // Advance one rising edge and update the reference state/counters
    task automatic step(input int kind, input logic go);
        @(posedge in_CLK);
        if (mstate != 1) mcyc++;
        if (kind == K_STALL) mstall++;
        if (kind == K_FLUSH) mflush++;
        case (mstate)
            0:       if (kind == K_FRZ) mstate = 1;
            1:       if (go) mstate = 2;
            default: mstate = 0;
        endcase
        #1;
    endtask

    task automatic test_reset();
        in_CLR = 1'b1;
        clear_inputs();
        model_reset();
        #2;
        sb.push_back(S_FRZ);
        exp_s = sb.pop_front(); checks++;
        if (strb_now() !== exp_s) begin errors++;
            $display("FAIL reset_strobes got=%b exp=%b", strb_now(), exp_s); end
        checks++;
        if (out_cycles !== 0 || out_stalls !== 0 || out_flushes !== 0) begin errors++;
            $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", out_cycles, out_stalls, out_flushes); end
        ex_branch_taken = 1'b1;
        @(posedge in_CLK); #1;
        sb.push_back(S_FRZ);
        exp_s = sb.pop_front(); checks++;
        if (strb_now() !== exp_s || out_cycles !== 0) begin errors++;
            $display("FAIL reset_held got=%b cyc=%0d exp=%b cyc=0", strb_now(), out_cycles, exp_s); end
        clear_inputs();
        @(negedge in_CLK);
        in_CLR = 1'b0;
        step(K_NORM, 1'b0);
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_wr_reg = 5'd5; id_use_rs = 1'b1; id_rs = 5'd5;
        sb.push_back(S_STALL);
        @(negedge in_CLK);
        exp_s = sb.pop_front(); checks++;
        if (strb_now() !== exp_s) begin errors++;
            $display("FAIL load_use_stall got=%b exp=%b", strb_now(), exp_s); end
        checks++;
        if (out_stalls !== 0) begin errors++;
            $display("FAIL load_use_stalls_before got=%0d exp=0", out_stalls); end
        step(K_STALL, 1'b0);
        ex_mem_read = 1'b0;
        sb.push_back(S_NORM);
        @(negedge in_CLK);
        exp_s = sb.pop_front(); checks++;
        if (strb_now() !== exp_s) begin errors++;
            $display("FAIL load_use_after got=%b exp=%b", strb_now(), exp_s); end
        checks++;
        if (out_stalls !== 1 || out_cycles !== mcyc) begin errors++;
            $display("FAIL load_use_counters got=%0d/%0d exp=1/%0d", out_stalls, out_cycles, mcyc); end
        step(K_NORM, 1'b0);
        clear_inputs();
    endtask

    task automatic test_no_stall();
        logic [4:0] wr_tab [3] = '{5'd0, 5'd5, 5'd9};
        logic       use_tab[3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0] exp_tab[3] = '{S_NORM, S_NORM, S_STALL};
        int         kind_tab[3] = '{K_NORM, K_NORM, K_STALL};
        for (int i = 0; i < 3; i++) begin
            ex_mem_read = 1'b1; ex_wr_reg = wr_tab[i];
            id_rs = 5'd0; id_use_rs = use_tab[i];
            id_rt = wr_tab[i]; id_use_rt = (i == 2);
            if (i == 1) id_rs = 5'd5;
            sb.push_back(exp_tab[i]);
            @(negedge in_CLK);
            exp_s = sb.pop_front(); checks++;
            if (strb_now() !== exp_s) begin errors++;
                $display("FAIL no_stall_case%0d got=%b exp=%b", i, strb_now(), exp_s); end
            checks++;
            if (out_stalls !== mstall) begin errors++;
                $display("FAIL no_stall_count%0d got=%0d exp=%0d", i, out_stalls, mstall); end
            step(kind_tab[i], 1'b0);
        end
        clear_inputs();
    endtask

    task automatic test_flush_over_stall();
        ex_branch_taken = 1'b1;
        ex_mem_read = 1'b1; ex_wr_reg = 5'd5; id_use_rs = 1'b1; id_rs = 5'd5;
        sb.push_back(S_FLUSH);
        @(negedge in_CLK);
        exp_s = sb.pop_front(); checks++;
        if (strb_now() !== exp_s) begin errors++;
            $display("FAIL flush_strobes got=%b exp=%b", strb_now(), exp_s); end
        step(K_FLUSH, 1'b0);
        clear_inputs();
        @(negedge in_CLK);
        checks++;
        if (out_flushes !== mflush || out_stalls !== mstall) begin errors++;
            $display("FAIL flush_counters got=%0d/%0d exp=%0d/%0d", out_flushes, out_stalls, mflush, mstall); end
        step(K_NORM, 1'b0);
    endtask

    task automatic test_halt();
        logic [31:0] frozen;
        wb_halt = 1'b1;
        sb.push_back(S_FRZ);
        @(negedge in_CLK);
        exp_s = sb.pop_front(); checks++;
        if (strb_now() !== exp_s) begin errors++;
            $display("FAIL halt_ev_strobes got=%b exp=%b", strb_now(), exp_s); end
        step(K_FRZ, 1'b0);
        frozen = mcyc;
        for (int i = 0; i < 10; i++) begin
            sb.push_back(S_HALTED);
            @(negedge in_CLK);
            exp_s = sb.pop_front(); checks++;
            if (strb_now() !== exp_s || out_cycles !== frozen) begin errors++;
                $display("FAIL halt_frozen%0d got=%b cyc=%0d exp=%b cyc=%0d",
                         i, strb_now(), out_cycles, exp_s, frozen); end
            step(K_FRZ, 1'b0);
        end
    endtask

    task automatic test_resume();
        in_go = 1'b1;
        sb.push_back(S_HALTED);
        @(negedge in_CLK);
        exp_s = sb.pop_front(); checks++;
        if (strb_now() !== exp_s) begin errors++;
            $display("FAIL resume_go_cycle got=%b exp=%b", strb_now(), exp_s); end
        step(K_FRZ, 1'b1);
        in_go = 1'b0;
        sb.push_back(S_NORM);
        @(negedge in_CLK);
        exp_s = sb.pop_front(); checks++;
        if (strb_now() !== exp_s) begin errors++;
            $display("FAIL resume_state got=%b exp=%b", strb_now(), exp_s); end
        step(K_NORM, 1'b0);
        wb_halt = 1'b0;
        in_go = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(S_NORM);
            @(negedge in_CLK);
            exp_s = sb.pop_front(); checks++;
            if (strb_now() !== exp_s || out_cycles !== mcyc) begin errors++;
                $display("FAIL run_go_ignored%0d got=%b cyc=%0d exp=%b cyc=%0d",
                         i, strb_now(), out_cycles, exp_s, mcyc); end
            step(K_NORM, 1'b1);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic lu;
        for (int i = 0; i < 40; i++) begin
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_wr_reg = 5'($urandom_range(0, 3));
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom_range(0, 1));
            id_use_rt = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            in_go = 1'($urandom_range(0, 1));
            lu = ex_mem_read && ex_wr_reg != 5'd0 &&
                 ((id_use_rs && id_rs == ex_wr_reg) || (id_use_rt && id_rt == ex_wr_reg));
            sb.push_back(ex_branch_taken ? S_FLUSH : (lu ? S_STALL : S_NORM));
            @(negedge in_CLK);
            exp_s = sb.pop_front(); checks++;
            if (strb_now() !== exp_s) begin errors++;
                $display("FAIL random%0d got=%b exp=%b", i, strb_now(), exp_s); end
            step(ex_branch_taken ? K_FLUSH : (lu ? K_STALL : K_NORM), in_go);
        end
        clear_inputs();
        @(negedge in_CLK);
        checks++;
        if (out_cycles !== mcyc || out_stalls !== mstall || out_flushes !== mflush) begin errors++;
            $display("FAIL random_counters got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     out_cycles, out_stalls, out_flushes, mcyc, mstall, mflush); end
        step(K_NORM, 1'b0);
    endtask

    task automatic test_clr_in_halt();
        #2; in_CLR = 1'b1; #1; in_CLR = 1'b0;
        model_reset();
        while (mcyc < 36) step(K_NORM, 1'b0);
        wb_halt = 1'b1;
        step(K_FRZ, 1'b0);
        for (int i = 0; i < 3; i++) step(K_FRZ, 1'b0);
        @(negedge in_CLK);
        checks++;
        if (out_cycles !== 37 || out_halted !== 1'b1) begin errors++;
            $display("FAIL clr_pre_halt got=cyc %0d halted %b exp=cyc 37 halted 1", out_cycles, out_halted); end
        step(K_FRZ, 1'b0);
        #2; in_CLR = 1'b1; #1;
        model_reset();
        sb.push_back(S_FRZ);
        exp_s = sb.pop_front(); checks++;
        if (strb_now() !== exp_s || out_cycles !== 0 || out_stalls !== 0 || out_flushes !== 0) begin errors++;
            $display("FAIL clr_async got=%b cyc=%0d exp=%b cyc=0", strb_now(), out_cycles, exp_s); end
        wb_halt = 1'b0;
        @(negedge in_CLK);
        in_CLR = 1'b0;
        #1;
        sb.push_back(S_NORM);
        exp_s = sb.pop_front(); checks++;
        if (strb_now() !== exp_s) begin errors++;
            $display("FAIL clr_release_run got=%b exp=%b", strb_now(), exp_s); end
        step(K_NORM, 1'b0);
        @(negedge in_CLK);
        checks++;
        if (out_cycles !== mcyc || out_halted !== 1'b0) begin errors++;
            $display("FAIL clr_after_count got=%0d halted %b exp=%0d halted 0", out_cycles, out_halted, mcyc); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_flush_over_stall();
        test_halt();
        test_resume();
        test_random();
        test_clr_in_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
